// File: rtl/acc_datapath_seq.sv
// Accumulator datapath: A register, operand bank, add/sub with signed overflow,
// and an n-step shift-add multiplier. Optional saturation via ACC_SATURATE_EN.
module acc_datapath_seq #(
   parameter int unsigned n  = 8,
   parameter int unsigned AW = 2
) (
   input  logic          clk,
   input  logic          clear,
   input  logic [2:0]    op,
   input  logic          op_valid,
   output logic          op_ready,
   input  logic [AW-1:0] addr,
   input  logic [n-1:0]  ir_data,
   input  logic [n-1:0]  in_data,
   output logic [n-1:0]  regAOut,
   output logic          Aeq0,
   output logic          Apos,
   output logic          ovf,
   output logic          done
);

   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned PW    = 2 * n;
   localparam int unsigned CW    = $clog2(n);

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_LDIN = 3'd1;
   localparam logic [2:0] OP_LDI  = 3'd2;
   localparam logic [2:0] OP_ADD  = 3'd3;
   localparam logic [2:0] OP_SUB  = 3'd4;
   localparam logic [2:0] OP_STA  = 3'd5;
   localparam logic [2:0] OP_MUL  = 3'd6;
   localparam logic [2:0] OP_CLR  = 3'd7;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t        state_q;
   logic [n-1:0]  a_q;
   logic [n-1:0]  bank_q [DEPTH];
   logic          ovf_q;
   logic          done_q;
   logic          ready_q;
   logic [PW-1:0] prod_q;
   logic [PW-1:0] mcand_q;
   logic [n-1:0]  mplier_q;
   logic [CW-1:0] cnt_q;

   logic [n-1:0]  operand_c;
   logic [n-1:0]  add_c;
   logic [n-1:0]  sub_c;
   logic          add_ovf_c;
   logic          sub_ovf_c;
   logic [n-1:0]  sat_c;
   logic [n-1:0]  add_res_c;
   logic [n-1:0]  sub_res_c;
   logic [PW-1:0] mul_step_c;
   logic          mul_hi_nz_c;
   logic [n-1:0]  mul_res_c;

   // Arithmetic results and overflow; overflow direction follows the sign of A.
   always_comb begin
      operand_c   = bank_q[addr];
      add_c       = a_q + operand_c;
      sub_c       = a_q - operand_c;
      add_ovf_c   = (a_q[n-1] == operand_c[n-1]) && (add_c[n-1] != a_q[n-1]);
      sub_ovf_c   = (a_q[n-1] != operand_c[n-1]) && (sub_c[n-1] != a_q[n-1]);
      sat_c       = a_q[n-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
      mul_step_c  = prod_q + (mplier_q[0] ? mcand_q : '0);
      mul_hi_nz_c = |mul_step_c[PW-1:n];
`ifdef ACC_SATURATE_EN
      add_res_c   = add_ovf_c ? sat_c : add_c;
      sub_res_c   = sub_ovf_c ? sat_c : sub_c;
      mul_res_c   = mul_hi_nz_c ? {n{1'b1}} : mul_step_c[n-1:0];
`else
      add_res_c   = add_c;
      sub_res_c   = sub_c;
      mul_res_c   = mul_step_c[n-1:0];
`endif
   end

   // Control FSM and all architectural state.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            bank_q[i] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (op_valid) begin
                  done_q <= 1'b1;
                  case (op)
                     OP_LDIN: a_q <= in_data;
                     OP_LDI:  a_q <= ir_data;
                     OP_ADD: begin
                        a_q   <= add_res_c;
                        ovf_q <= add_ovf_c;
                     end
                     OP_SUB: begin
                        a_q   <= sub_res_c;
                        ovf_q <= sub_ovf_c;
                     end
                     OP_STA:  bank_q[addr] <= a_q;
                     OP_MUL: begin
                        done_q   <= 1'b0;
                        mcand_q  <= PW'(a_q);
                        mplier_q <= operand_c;
                        prod_q   <= '0;
                        cnt_q    <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= S_MUL;
                     end
                     OP_CLR: begin
                        a_q   <= '0;
                        ovf_q <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               prod_q   <= mul_step_c;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               // Last step commits the product straight from the adder output.
               if (cnt_q == CW'(n - 1)) begin
                  a_q     <= mul_res_c;
                  ovf_q   <= mul_hi_nz_c;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign op_ready = ready_q;
   assign regAOut  = a_q;
   assign ovf      = ovf_q;
   assign done     = done_q;
   assign Aeq0     = (a_q == '0);
   assign Apos     = ~a_q[n-1] & (a_q != '0);

endmodule

// File: tb/tb_acc_datapath_seq.sv
// Randomized scoreboard bench for acc_datapath_seq against an arithmetic reference model.
module tb_acc_datapath_seq;

   localparam int unsigned N  = 8;
   localparam int unsigned AW = 2;

   logic          clk = 1'b0;
   logic          clear;
   logic [2:0]    op;
   logic          op_valid;
   logic          op_ready;
   logic [AW-1:0] addr;
   logic [N-1:0]  ir_data;
   logic [N-1:0]  in_data;
   logic [N-1:0]  regAOut;
   logic          Aeq0;
   logic          Apos;
   logic          ovf;
   logic          done;

   acc_datapath_seq #(.n(N), .AW(AW)) dut (
      .clk(clk), .clear(clear), .op(op), .op_valid(op_valid), .op_ready(op_ready),
      .addr(addr), .ir_data(ir_data), .in_data(in_data), .regAOut(regAOut),
      .Aeq0(Aeq0), .Apos(Apos), .ovf(ovf), .done(done)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   logic [N:0]   exp_q [$];
   logic [N-1:0] m_a;
   logic         m_ovf;
   logic [N-1:0] m_bank [4];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_a   = '0;
      m_ovf = 1'b0;
      foreach (m_bank[i]) m_bank[i] = '0;
      exp_q.delete();
   endfunction

   // Reference: plain integer arithmetic on the programmer-visible state.
   function automatic void model(logic [2:0] o, logic [1:0] a, logic [7:0] ir, logic [7:0] in);
      int x, y, s, p;
      x = int'(m_a);
      y = int'(m_bank[a]);
      case (o)
         3'd1: m_a = in;
         3'd2: m_a = ir;
         3'd3, 3'd4: begin
            if (x > 127) x -= 256;
            if (y > 127) y -= 256;
            s = (o == 3'd3) ? x + y : x - y;
            m_ovf = (s > 127) || (s < -128);
`ifdef ACC_SATURATE_EN
            if (s > 127)  s = 127;
            if (s < -128) s = -128;
`endif
            m_a = 8'(s);
         end
         3'd5: m_bank[a] = m_a;
         3'd6: begin
            p = x * y;
            m_ovf = (p > 255);
`ifdef ACC_SATURATE_EN
            if (p > 255) p = 255;
`endif
            m_a = 8'(p);
         end
         3'd7: begin
            m_a   = '0;
            m_ovf = 1'b0;
         end
         default: ;
      endcase
      exp_q.push_back({m_ovf, m_a});
   endfunction

   // Monitor: every done pulse consumes one expected result.
   always @(negedge clk) begin
      logic [N:0] e;
      if (clear === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL spurious_done: got done=1 expected no pending op at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("acc", 32'(regAOut), 32'(e[N-1:0]));
            chk("ovf", 32'(ovf), 32'(e[N]));
            chk("aeq0", 32'(Aeq0), 32'(e[N-1:0] == '0));
            chk("apos", 32'(Apos), 32'(!e[N-1] && e[N-1:0] != '0));
         end
      end
   end

   // Called at a negedge; holds the op over one rising edge once ready.
   task automatic issue(logic [2:0] o, logic [1:0] a, logic [7:0] ir, logic [7:0] in);
      int t = 0;
      while (!op_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!op_ready) begin
         compared++;
         mismatched++;
         $display("FAIL ready_timeout: got op_ready=0 expected 1 within 200 cycles");
         return;
      end
      op = o; addr = a; ir_data = ir; in_data = in; op_valid = 1'b1;
      model(o, a, ir, in);
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   function automatic logic [7:0] pick_val();
      logic [7:0] v;
      case ($urandom_range(0, 7))
         0: v = 8'h00;
         1: v = 8'h01;
         2: v = 8'h7F;
         3: v = 8'h80;
         4: v = 8'hFF;
         default: v = 8'($urandom);
      endcase
      return v;
   endfunction

   initial begin
      int cnt;
      clear = 1'b0; op = '0; op_valid = 1'b0; addr = '0; ir_data = '0; in_data = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_a", 32'(regAOut), 32'h0);
      chk("rst_ready", 32'(op_ready), 32'h1);
      clear = 1'b1;
      @(negedge clk);

      // Directed: load/store/subtract, negative result, clear.
      issue(3'd1, 2'd1, 8'h00, 8'h03);
      issue(3'd5, 2'd1, 8'h00, 8'h00);
      issue(3'd2, 2'd0, 8'h05, 8'h00);
      issue(3'd4, 2'd1, 8'h00, 8'h00);
      issue(3'd2, 2'd0, 8'h00, 8'h00);
      issue(3'd4, 2'd1, 8'h00, 8'h00);
      issue(3'd7, 2'd0, 8'h00, 8'h00);
      // Signed add overflow.
      issue(3'd2, 2'd0, 8'h01, 8'h00);
      issue(3'd5, 2'd2, 8'h00, 8'h00);
      issue(3'd2, 2'd0, 8'h7F, 8'h00);
      issue(3'd3, 2'd2, 8'h00, 8'h00);
      // Multiply 12*11 with busy-time LDI attempts that must be ignored.
      issue(3'd2, 2'd0, 8'd11, 8'h00);
      issue(3'd5, 2'd3, 8'h00, 8'h00);
      issue(3'd2, 2'd0, 8'd12, 8'h00);
      issue(3'd6, 2'd3, 8'h00, 8'h00);
      cnt = 0;
      while (!op_ready && cnt < 100) begin
         op = 3'd2; ir_data = 8'h55; op_valid = 1'b1;
         @(negedge clk);
         cnt++;
      end
      op_valid = 1'b0;
      chk("mul_busy_cycles", 32'(cnt), 32'd8);
      // Multiply with high half nonzero.
      issue(3'd2, 2'd0, 8'h10, 8'h00);
      issue(3'd5, 2'd3, 8'h00, 8'h00);
      issue(3'd2, 2'd0, 8'h20, 8'h00);
      issue(3'd6, 2'd3, 8'h00, 8'h00);

      // Reset in the middle of a multiply.
      issue(3'd2, 2'd0, 8'h33, 8'h00);
      issue(3'd6, 2'd1, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      clear = 1'b0;
      #1;
      chk("midmul_rst_a", 32'(regAOut), 32'h0);
      chk("midmul_rst_aeq0", 32'(Aeq0), 32'h1);
      chk("midmul_rst_apos", 32'(Apos), 32'h0);
      chk("midmul_rst_ovf", 32'(ovf), 32'h0);
      chk("midmul_rst_ready", 32'(op_ready), 32'h1);
      chk("midmul_rst_done", 32'(done), 32'h0);
      model_reset();
      repeat (2) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      // Bank must read zero everywhere after reset.
      for (int i = 0; i < 4; i++) begin
         issue(3'd2, 2'd0, 8'h01, 8'h00);
         issue(3'd3, 2'(i), 8'h00, 8'h00);
      end

      // Random traffic with idle gaps.
      for (int i = 0; i < 400; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), pick_val(), pick_val());
      end

      repeat (20) @(negedge clk);
      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
